// File: rtl/idma_desc64_token_drain.sv
// Consumer end of the descriptor-frontend token counter: pulls tokens one per
// cycle, coalesces them into batches and hands each batch downstream.
module idma_desc64_token_drain #(
    parameter int unsigned MaxBatch   = 4,
    parameter int unsigned Timeout    = 8,
    parameter int unsigned CountWidth = $clog2(MaxBatch + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  greater_than_zero_i,
    output logic                  decrement_o,
    input  logic                  flush_i,
    output logic                  batch_valid_o,
    input  logic                  batch_ready_i,
    output logic [CountWidth-1:0] batch_count_o,
    output logic                  busy_o
);

    localparam int unsigned TimerWidth = $clog2(Timeout + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_e;

    state_e                state_q;
    logic [CountWidth-1:0] batch_q;
    logic [TimerWidth-1:0] timer_q;
    logic                  valid_q;
    logic [CountWidth-1:0] count_q;
    logic                  busy_q;

    logic                  take;
    logic [CountWidth:0]   batch_sum;
    logic                  close;
    logic [TimerWidth-1:0] timer_inc;

    // Take depends only on registered state and the counter's registered flag,
    // so no combinational loop forms through the counter.
    assign take = rst_ni && greater_than_zero_i &&
                  ((state_q == IDLE) ||
                   ((state_q == COLLECT) && (batch_q < CountWidth'(MaxBatch))));

    // One extra bit keeps the full-batch compare exact for any MaxBatch.
    assign batch_sum = {1'b0, batch_q} + {{CountWidth{1'b0}}, take};

    assign close = (batch_sum == (CountWidth + 1)'(MaxBatch)) ||
                   (timer_q == TimerWidth'(Timeout - 1)) ||
                   flush_i;

    assign timer_inc = (timer_q == TimerWidth'(Timeout)) ? timer_q
                                                         : timer_q + TimerWidth'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            batch_q <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        batch_q <= CountWidth'(1);
                        timer_q <= '0;
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    batch_q <= batch_sum[CountWidth-1:0];
                    timer_q <= timer_inc;
                    // A token taken in the closing cycle rides along in this batch.
                    if (close) begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                        count_q <= batch_sum[CountWidth-1:0];
                    end
                end
                ISSUE: begin
                    if (batch_ready_i) begin
                        batch_q <= '0;
                        timer_q <= '0;
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign decrement_o   = take;
    assign batch_valid_o = valid_q;
    assign batch_count_o = count_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_idma_desc64_token_drain.sv
// Directed bench for idma_desc64_token_drain: a MaxBatch=4/Timeout=8 instance
// plus a MaxBatch=1 instance, with a per-instance queue of expected batch counts.
module tb_idma_desc64_token_drain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag0, flush0, ready0, dec0, valid0, busy0;
    logic [2:0] count0;
    logic       flag1, flush1, ready1, dec1, valid1, busy1;
    logic [0:0] count1;

    int tests = 0;
    int fails = 0;
    int ndec0 = 0;
    int ndec1 = 0;
    int d0, d1;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    idma_desc64_token_drain #(.MaxBatch(4), .Timeout(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .greater_than_zero_i(flag0), .decrement_o(dec0),
        .flush_i(flush0), .batch_valid_o(valid0), .batch_ready_i(ready0),
        .batch_count_o(count0), .busy_o(busy0)
    );

    idma_desc64_token_drain #(.MaxBatch(1), .Timeout(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .greater_than_zero_i(flag1), .decrement_o(dec1),
        .flush_i(flush1), .batch_valid_o(valid1), .batch_ready_i(ready1),
        .batch_count_o(count1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: count decrement pulses and check every handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dec0) ndec0++;
            if (dec1) ndec1++;
            if (valid0 && ready0) begin
                if (q0.size() == 0) chk("unexpected_batch0", 32'd1, 32'd0);
                else chk("batch0_count", 32'(count0), 32'(q0.pop_front()));
            end
            if (valid1 && ready1) begin
                if (q1.size() == 0) chk("unexpected_batch1", 32'd1, 32'd0);
                else chk("batch1_count", 32'(count1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flag0 = 1'b1; flush0 = 1'b0; ready0 = 1'b1;
        flag1 = 1'b0; flush1 = 1'b0; ready1 = 1'b1;

        // Reset held two cycles with the flag asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_dec", 32'(dec0), 32'd0);
            chk("rst_valid", 32'(valid0), 32'd0);
            chk("rst_busy", 32'(busy0), 32'd0);
            chk("rst_count", 32'(count0), 32'd0);
        end

        // Burst: four consecutive takes, batch of 4
        d0 = ndec0;
        q0.push_back(4);
        rst_n = 1'b1;
        #1;
        chk("take_after_reset", 32'(dec0), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("burst_dec", 32'(dec0), 32'd1);
            chk("burst_valid_low", 32'(valid0), 32'd0);
        end
        tick();
        chk("burst_valid", 32'(valid0), 32'd1);
        chk("burst_count", 32'(count0), 32'd4);
        chk("burst_no_dec_issue", 32'(dec0), 32'd0);
        flag0 = 1'b0;
        tick();
        chk("burst_idle_busy", 32'(busy0), 32'd0);
        chk("burst_idle_count", 32'(count0), 32'd0);
        chk("burst_ndec", 32'(ndec0 - d0), 32'd4);

        // Timeout: one token, batch issued nine cycles later
        d0 = ndec0;
        q0.push_back(1);
        flag0 = 1'b1;
        tick();
        flag0 = 1'b0;
        for (int i = 1; i < 9; i++) begin
            chk("timeout_wait_valid", 32'(valid0), 32'd0);
            chk("timeout_wait_busy", 32'(busy0), 32'd1);
            tick();
        end
        chk("timeout_valid", 32'(valid0), 32'd1);
        chk("timeout_count", 32'(count0), 32'd1);
        tick();
        chk("timeout_idle", 32'(busy0), 32'd0);
        chk("timeout_ndec", 32'(ndec0 - d0), 32'd1);

        // Flush in IDLE does nothing
        flush0 = 1'b1;
        tick();
        chk("flush_idle_busy", 32'(busy0), 32'd0);
        chk("flush_idle_valid", 32'(valid0), 32'd0);
        flush0 = 1'b0;

        // Flush closes a two-token batch; flush during ISSUE is ignored
        d0 = ndec0;
        q0.push_back(2);
        flag0 = 1'b1;
        tick();
        tick();
        flag0 = 1'b0; flush0 = 1'b1; ready0 = 1'b0;
        tick();
        chk("flush_valid", 32'(valid0), 32'd1);
        chk("flush_count", 32'(count0), 32'd2);
        tick();
        chk("flush_issue_hold_valid", 32'(valid0), 32'd1);
        chk("flush_issue_hold_count", 32'(count0), 32'd2);
        flush0 = 1'b0; ready0 = 1'b1;
        tick();
        chk("flush_idle_after", 32'(busy0), 32'd0);
        chk("flush_ndec", 32'(ndec0 - d0), 32'd2);

        // Backpressure: ISSUE held 20 cycles with the flag up
        d0 = ndec0;
        q0.push_back(4);
        ready0 = 1'b0; flag0 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(valid0), 32'd1);
            chk("bp_count", 32'(count0), 32'd4);
            chk("bp_dec", 32'(dec0), 32'd0);
            tick();
        end
        ready0 = 1'b1; flag0 = 1'b0;
        tick();
        chk("bp_idle", 32'(busy0), 32'd0);
        chk("bp_ndec", 32'(ndec0 - d0), 32'd4);

        // Reset while collecting three tokens drops the batch
        d0 = ndec0;
        flag0 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flag0 = 1'b0;
        chk("midrst_busy_before", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("midrst_no_valid", 32'(valid0), 32'd0);
            tick();
        end
        chk("midrst_ndec", 32'(ndec0 - d0), 32'd3);

        // MaxBatch=1: each token is its own batch, issued two cycles after the take
        d1 = ndec1;
        flag1 = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            q1.push_back(1);
            chk("mb1_take", 32'(dec1), 32'd1);
            tick();
            chk("mb1_collect_dec", 32'(dec1), 32'd0);
            chk("mb1_collect_valid", 32'(valid1), 32'd0);
            if (k == 2) flag1 = 1'b0;
            tick();
            chk("mb1_valid", 32'(valid1), 32'd1);
            chk("mb1_count", 32'(count1), 32'd1);
            tick();
        end
        chk("mb1_idle", 32'(busy1), 32'd0);
        chk("mb1_ndec", 32'(ndec1 - d1), 32'd3);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
